// File: rtl/regbus_share_pkg.sv
// Shared types and helpers for the regbus share arbiter.
package regbus_share_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    // Index width that never collapses to zero for single-entry vectors.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_pick
    import regbus_share_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdxW   = clog2_min1(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              valid
);

    localparam int PosW = clog2_min1(2 * NumReq);

    logic [2*NumReq-1:0] dbl;
    logic [PosW-1:0]     pos;

    // Upper copy keeps every request; lower copy loses those below ptr, so the
    // lowest surviving bit is the next requester in round-robin order.
    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < NumReq; i++) begin
            if (i < int'(ptr)) dbl[i] = 1'b0;
        end
        pos = '0;
        for (int i = 2 * NumReq - 1; i >= 0; i--) begin
            if (dbl[i]) pos = PosW'(i);
        end
        if (int'(pos) >= NumReq) pos = pos - PosW'(NumReq);
        idx   = IdxW'(pos);
        valid = |req;
    end

endmodule

// File: rtl/regbus_share_arbiter.sv
// Round-robin share of one regbus target among NumReq requesters, with a
// watchdog that answers with an error when the target never becomes ready.
module regbus_share_arbiter
    import regbus_share_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int AddrWidth     = 48,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_write_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
    output logic [NumReq-1:0]               rsp_ready_o,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            rsp_error_o,
    output logic                            mst_valid_o,
    output logic [AddrWidth-1:0]            mst_addr_o,
    output logic                            mst_write_o,
    output logic [DataWidth-1:0]            mst_wdata_o,
    output logic [DataWidth/8-1:0]          mst_wstrb_o,
    input  logic                            mst_ready_i,
    input  logic [DataWidth-1:0]            mst_rdata_i,
    input  logic                            mst_error_i,
    output logic                            busy_o,
    output logic [7:0]                      timeout_cnt_o
);

    localparam int IdxW  = clog2_min1(NumReq);
    localparam int TmoW  = clog2_min1(TimeoutCycles);
    localparam int StrbW = DataWidth / 8;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_q, ptr_q, pick_idx, ptr_adv;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      timeout_cnt_q;
    logic            pick_valid, busy, gnt_valid, done, tmo_hit;

    rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign busy      = (state_q == BUSY);
    assign gnt_valid = req_valid_i[grant_q];

    // Target side follows the granted slice; quiet zeros while idle.
    assign mst_valid_o = busy & gnt_valid;
    assign mst_addr_o  = busy ? req_addr_i[int'(grant_q)*AddrWidth +: AddrWidth] : '0;
    assign mst_write_o = busy & req_write_i[grant_q];
    assign mst_wdata_o = busy ? req_wdata_i[int'(grant_q)*DataWidth +: DataWidth] : '0;
    assign mst_wstrb_o = busy ? req_wstrb_i[int'(grant_q)*StrbW +: StrbW] : '0;

    // A ready on the last watchdog cycle is a normal completion.
    assign done    = mst_valid_o & mst_ready_i;
    assign tmo_hit = mst_valid_o & ~mst_ready_i & (tmo_q == TmoLast);
    assign ptr_adv = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

    always_comb begin
        rsp_ready_o          = '0;
        rsp_ready_o[grant_q] = done | tmo_hit;
        rsp_rdata_o          = done ? mst_rdata_i : '0;
        rsp_error_o          = done ? mst_error_i : tmo_hit;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_valid) state_d = BUSY;
            BUSY: if (!gnt_valid || done || tmo_hit) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A dropped valid returns to IDLE without moving ptr or counting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q       <= '0;
            ptr_q         <= '0;
            tmo_q         <= '0;
            timeout_cnt_q <= '0;
        end else if (!busy) begin
            if (pick_valid) begin
                grant_q <= pick_idx;
                tmo_q   <= '0;
            end
        end else if (done || tmo_hit) begin
            ptr_q <= ptr_adv;
            if (tmo_hit && timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end else if (gnt_valid) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign busy_o        = busy;
    assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_regbus_share_arbiter.sv
// Scoreboard bench for regbus_share_arbiter: requester and target models, a
// response monitor popping expectations in completion order.
module tb_regbus_share_arbiter;

    localparam int N   = 4;
    localparam int AW  = 48;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic [N-1:0]      req_valid_i, req_write_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N*SW-1:0]   req_wstrb_i;
    logic [N-1:0]      rsp_ready_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_error_o;
    logic              mst_valid_o, mst_write_o, mst_ready_i, mst_error_i;
    logic [AW-1:0]     mst_addr_o;
    logic [DW-1:0]     mst_wdata_o, mst_rdata_i;
    logic [SW-1:0]     mst_wstrb_o;
    logic              busy_o;
    logic [7:0]        timeout_cnt_o;

    regbus_share_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_ready_o(rsp_ready_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .mst_valid_o(mst_valid_o), .mst_addr_o(mst_addr_o), .mst_write_o(mst_write_o),
        .mst_wdata_o(mst_wdata_o), .mst_wstrb_o(mst_wstrb_o),
        .mst_ready_i(mst_ready_i), .mst_rdata_i(mst_rdata_i), .mst_error_i(mst_error_i),
        .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_vec = 0, n_err = 0;
    int     cyc_n = 0, last_cyc = 0;
    int     reissue[N];
    bit     gap_chk = 0, have_last = 0;
    logic [N-1:0] last_rdy = '0;

    // Target model: ready after tgt_delay waiting cycles unless dead.
    logic          tgt_dead = 1'b0, tgt_err = 1'b0;
    int            tgt_delay = 0, wcnt = 0;
    logic [DW-1:0] tgt_xor = '0;

    assign mst_ready_i = mst_valid_o && !tgt_dead && (wcnt >= tgt_delay);
    assign mst_rdata_i = tgt_xor ^ mst_addr_o[DW-1:0];
    assign mst_error_i = tgt_err;
    always @(posedge clk) wcnt <= (mst_valid_o && !mst_ready_i) ? wcnt + 1 : 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        last_rdy = rsp_ready_o;
        if (rsp_ready_o != '0) begin
            if (sb.size() == 0) chk("rsp_unexpected", 64'(rsp_ready_o), 64'd0);
            else begin
                mon_e = sb.pop_front();
                chk("rsp_vec",   64'(rsp_ready_o), 64'(1) << mon_e.idx);
                chk("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_e.rdata));
                chk("rsp_err",   64'(rsp_error_o), 64'(mon_e.err));
                if (gap_chk && have_last) chk("rsp_gap", 64'(cyc_n - last_cyc), 64'd2);
                last_cyc  = cyc_n;
                have_last = 1;
            end
        end
    end

    task automatic push_exp(input int i, input logic [AW-1:0] a);
        exp_t e;
        e.idx   = i;
        e.rdata = tgt_dead ? '0 : (tgt_xor ^ a[DW-1:0]);
        e.err   = tgt_dead ? 1'b1 : tgt_err;
        sb.push_back(e);
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a, input logic w, input int reiss);
        req_valid_i[i]          = 1'b1;
        req_addr_i[i*AW +: AW]  = a;
        req_write_i[i]          = w;
        req_wdata_i[i*DW +: DW] = $urandom;
        req_wstrb_i[i*SW +: SW] = SW'($urandom);
        reissue[i]              = reiss;
        push_exp(i, a);
    endtask

    // One clock; completed requesters either reissue a fresh transfer or drop valid.
    task automatic cyc();
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < N; i++) begin
            if (last_rdy[i]) begin
                if (reissue[i] > 0) begin
                    a = req_addr_i[i*AW +: AW] + 48'h10;
                    issue(i, a, req_write_i[i], reissue[i] - 1);
                end else req_valid_i[i] = 1'b0;
            end
        end
        last_rdy = '0;
    endtask

    task automatic do_reset();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        rst_i = 1'b1;
        req_valid_i = '0;
        sb.delete();
        for (int i = 0; i < N; i++) reissue[i] = 0;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        for (int i = 0; i < N; i++) reissue[i] = 0;
        #1 rst_i = 1'b1;
        @(negedge clk);
        chk("rst_rdy",   64'(rsp_ready_o), 64'd0);
        chk("rst_mvld",  64'(mst_valid_o), 64'd0);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_tcnt",  64'(timeout_cnt_o), 64'd0);
        chk("rst_err",   64'(rsp_error_o), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("rst_addr",  64'(mst_addr_o), 64'd0);
        cyc();
        rst_i = 1'b0;

        // Single read with one wait cycle, then ptr must sit at 3.
        tgt_delay = 1;
        tgt_xor   = 32'hCAFE0001 ^ 32'h00001000;
        cyc();
        issue(2, 48'h1000, 1'b0, 0);
        @(negedge clk);
        chk("rd_c0_mvld", 64'(mst_valid_o), 64'd0);
        chk("rd_c0_rdy",  64'(rsp_ready_o), 64'd0);
        cyc(); @(negedge clk);
        chk("rd_c1_mvld", 64'(mst_valid_o), 64'd1);
        chk("rd_c1_addr", 64'(mst_addr_o), 64'h1000);
        chk("rd_c1_busy", 64'(busy_o), 64'd1);
        chk("rd_c1_rdy",  64'(rsp_ready_o), 64'd0);
        cyc(); @(negedge clk);
        chk("rd_c2_rdy",   64'(rsp_ready_o), 64'b0100);
        chk("rd_c2_rdata", 64'(rsp_rdata_o), 64'hCAFE0001);
        cyc();
        tgt_delay = 0;
        tgt_xor   = 32'h5A5A0000;
        issue(3, 48'h300, 1'b0, 0);
        issue(0, 48'h000, 1'b0, 0);
        repeat (8) cyc();

        // Fairness: all four continuously valid, target always ready.
        do_reset();
        have_last = 0;
        gap_chk   = 1;
        for (int i = 0; i < N; i++) issue(i, AW'(48'h1_0000_0000 + i * 48'h1000), 1'b0, 25);
        repeat (230) cyc();
        gap_chk = 0;
        chk("fair_sb", 64'(sb.size()), 64'd0);

        // Re-request: req1 reasserts right away but req3 goes first.
        do_reset();
        issue(1, 48'h100, 1'b0, 1);
        cyc();
        issue(3, 48'h300, 1'b0, 0);
        repeat (8) cyc();

        // Watchdog on a dead target, write payload visible on the target side.
        tgt_dead = 1'b1;
        issue(0, 48'h40, 1'b1, 0);
        for (int k = 1; k <= TMO; k++) begin
            cyc(); @(negedge clk);
            if (k == 1) begin
                chk("wr_write", 64'(mst_write_o), 64'd1);
                chk("wr_wdata", 64'(mst_wdata_o), 64'(req_wdata_i[0 +: DW]));
                chk("wr_wstrb", 64'(mst_wstrb_o), 64'(req_wstrb_i[0 +: SW]));
            end
            if (k < TMO) chk("tmo_wait", 64'({mst_valid_o, rsp_ready_o}), 64'(5'b10000));
            else         chk("tmo_hit",  64'({mst_valid_o, rsp_ready_o, rsp_error_o}), 64'(6'b100011));
        end
        cyc(); @(negedge clk);
        chk("tmo_cnt",  64'(timeout_cnt_o), 64'd1);
        chk("tmo_idle", 64'(busy_o), 64'd0);

        // Ready on the exact watchdog cycle: normal completion, no count.
        tgt_dead  = 1'b0;
        tgt_delay = 7;
        issue(0, 48'h80, 1'b0, 0);
        repeat (12) cyc();
        chk("tmo_edge_cnt", 64'(timeout_cnt_o), 64'd1);

        // Target error passthrough.
        tgt_delay = 0;
        tgt_err   = 1'b1;
        issue(2, 48'h200, 1'b0, 0);
        repeat (4) cyc();
        tgt_err = 1'b0;
        chk("err_cnt", 64'(timeout_cnt_o), 64'd1);

        // Reset mid-transfer: outputs drop at once and ptr returns to 0.
        issue(1, 48'h10, 1'b0, 0);
        repeat (3) cyc();
        tgt_dead = 1'b1;
        issue(2, 48'h20, 1'b0, 0);
        void'(sb.pop_back());
        cyc(); cyc(); @(negedge clk);
        chk("rb_mvld_pre", 64'(mst_valid_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rb_mvld",  64'(mst_valid_o), 64'd0);
        chk("rb_busy",  64'(busy_o), 64'd0);
        chk("rb_tcnt",  64'(timeout_cnt_o), 64'd0);
        chk("rb_rdy",   64'(rsp_ready_o), 64'd0);
        req_valid_i[2] = 1'b0;
        cyc();
        rst_i    = 1'b0;
        tgt_dead = 1'b0;
        cyc();
        issue(1, 48'h110, 1'b0, 0);
        issue(3, 48'h330, 1'b0, 0);
        repeat (6) cyc();

        // Granted requester drops valid: no response, ptr (3) unchanged.
        issue(2, 48'h220, 1'b0, 0);
        repeat (3) cyc();
        tgt_dead = 1'b1;
        issue(0, 48'h0, 1'b0, 0);
        void'(sb.pop_back());
        cyc(); cyc();
        req_valid_i[0] = 1'b0;
        #1;
        chk("drop_mvld", 64'(mst_valid_o), 64'd0);
        chk("drop_rdy",  64'(rsp_ready_o), 64'd0);
        cyc(); @(negedge clk);
        chk("drop_idle", 64'(busy_o), 64'd0);
        tgt_dead = 1'b0;
        issue(3, 48'h3300, 1'b0, 0);
        issue(1, 48'h1100, 1'b0, 0);
        repeat (6) cyc();
        chk("drop_tcnt", 64'(timeout_cnt_o), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
